// File: rtl/mlp_pkg.sv
// Shared types and helpers for the sequential two-layer MLP engine: FSM states,
// accumulator width functions and the output saturation function.
package mlp_pkg;

  typedef enum logic [1:0] {IDLE, L1, L2, OUT} state_e;

  function automatic int hw_width(input int dw, input int n_in);
    return 2*dw + $clog2(n_in);
  endfunction

  function automatic int aw_width(input int dw, input int n_in, input int n_hid);
    return hw_width(dw, n_in) + dw + $clog2(n_hid);
  endfunction

  // Clamp to the signed range of an ow-bit result; caller truncates to ow bits.
  function automatic logic signed [63:0] sat_ow(input logic signed [63:0] v, input int ow);
    logic signed [63:0] vmax;
    logic signed [63:0] vmin;
    vmax = (64'sd1 <<< (ow-1)) - 64'sd1;
    vmin = -vmax - 64'sd1;
    if (v > vmax) return vmax;
    else if (v < vmin) return vmin;
    else return v;
  endfunction

endpackage

// File: rtl/mlp_relu.sv
// Combinational ReLU on a signed value; zero latency, no flow control.
module mlp_relu #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] i_val,
  output logic signed [W-1:0] o_val
);

  assign o_val = i_val[W-1] ? '0 : i_val;

endmodule

// File: rtl/mlp_seq_engine.sv
// Sequential MLP: one input element per cycle in L1, one hidden neuron per cycle in L2.
// Latency N_IN+N_HID; result held in OUT until out_ready. MLP_SAT_EN selects saturating outputs.
module mlp_seq_engine
  import mlp_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int DW    = 5,
  parameter int OW    = 17,
  localparam int NW   = N_IN*N_HID + N_HID*N_OUT,
  localparam int WA   = $clog2(NW)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IN*DW-1:0]  x_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                w_we,
  input  logic [WA-1:0]       w_addr,
  input  logic [DW-1:0]       w_data,
  output logic [N_OUT*OW-1:0] y_out,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int NW1  = N_IN*N_HID;
  localparam int HW   = hw_width(DW, N_IN);
  localparam int AW   = aw_width(DW, N_IN, N_HID);
  localparam int CMAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int CW   = $clog2(CMAX + 1);

  state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic signed [DW-1:0] r_x  [N_IN];
  logic signed [DW-1:0] r_w1 [N_IN][N_HID];
  logic signed [DW-1:0] r_w2 [N_HID][N_OUT];
  logic signed [HW-1:0] r_h  [N_HID];
  logic signed [AW-1:0] r_a  [N_OUT];
  logic [N_OUT*OW-1:0]  r_y;

  logic signed [DW-1:0] w_xk;
  logic signed [DW-1:0] w_w1row [N_HID];
  logic signed [HW-1:0] w_rsel;
  logic signed [DW-1:0] w_w2row [N_OUT];
  logic signed [HW-1:0] w_relu  [N_HID];
  logic signed [HW-1:0] w_h_nxt [N_HID];
  logic signed [AW-1:0] w_a_nxt [N_OUT];
  logic [N_OUT*OW-1:0]  w_y_nxt;
  logic w_last_l1, w_last_l2;

  for (genvar j = 0; j < N_HID; j++) begin : g_relu
    mlp_relu #(.W(HW)) u_relu (.i_val(r_h[j]), .o_val(w_relu[j]));
  end

  assign w_last_l1 = (r_state == L1) && (r_cnt == CW'(N_IN-1));
  assign w_last_l2 = (r_state == L2) && (r_cnt == CW'(N_HID-1));

  // The counter selects the current input element (L1) or hidden neuron (L2).
  always_comb begin
    w_xk   = '0;
    w_rsel = '0;
    for (int j = 0; j < N_HID; j++) w_w1row[j] = '0;
    for (int o = 0; o < N_OUT; o++) w_w2row[o] = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (r_cnt == CW'(k)) begin
        w_xk = r_x[k];
        for (int j = 0; j < N_HID; j++) w_w1row[j] = r_w1[k][j];
      end
    end
    for (int h = 0; h < N_HID; h++) begin
      if (r_cnt == CW'(h)) begin
        w_rsel = w_relu[h];
        for (int o = 0; o < N_OUT; o++) w_w2row[o] = r_w2[h][o];
      end
    end
    for (int j = 0; j < N_HID; j++)
      w_h_nxt[j] = r_h[j] + HW'(w_xk) * HW'(w_w1row[j]);
    for (int o = 0; o < N_OUT; o++) begin
      w_a_nxt[o] = r_a[o] + AW'(w_rsel) * AW'(w_w2row[o]);
`ifdef MLP_SAT_EN
      w_y_nxt[o*OW +: OW] = OW'(sat_ow(64'(w_a_nxt[o]), OW));
`else
      w_y_nxt[o*OW +: OW] = OW'(64'(w_a_nxt[o]));
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = L1;
      end
      L1:  if (w_last_l1) w_state_nxt = L2;
      L2:  if (w_last_l2) w_state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_y   <= '0;
      for (int k = 0; k < N_IN; k++) begin
        r_x[k] <= '0;
        for (int j = 0; j < N_HID; j++) r_w1[k][j] <= '0;
      end
      for (int h = 0; h < N_HID; h++) begin
        r_h[h] <= '0;
        for (int o = 0; o < N_OUT; o++) r_w2[h][o] <= '0;
      end
      for (int o = 0; o < N_OUT; o++) r_a[o] <= '0;
    end else begin
      // Weights are only writable while idle so a running pass sees a stable set.
      if (w_we && r_state == IDLE) begin
        for (int k = 0; k < N_IN; k++)
          for (int j = 0; j < N_HID; j++)
            if (w_addr == WA'(k*N_HID + j)) r_w1[k][j] <= w_data;
        for (int h = 0; h < N_HID; h++)
          for (int o = 0; o < N_OUT; o++)
            if (w_addr == WA'(NW1 + h*N_OUT + o)) r_w2[h][o] <= w_data;
      end
      case (r_state)
        IDLE: if (in_valid) begin
          r_cnt <= '0;
          for (int k = 0; k < N_IN; k++) r_x[k] <= x_in[k*DW +: DW];
          for (int h = 0; h < N_HID; h++) r_h[h] <= '0;
          for (int o = 0; o < N_OUT; o++) r_a[o] <= '0;
        end
        L1: begin
          for (int j = 0; j < N_HID; j++) r_h[j] <= w_h_nxt[j];
          r_cnt <= w_last_l1 ? '0 : r_cnt + CW'(1);
        end
        L2: begin
          for (int o = 0; o < N_OUT; o++) r_a[o] <= w_a_nxt[o];
          r_cnt <= w_last_l2 ? '0 : r_cnt + CW'(1);
          if (w_last_l2) r_y <= w_y_nxt;
        end
        default: ;
      endcase
    end
  end

  assign y_out = r_y;

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Scoreboard bench for mlp_seq_engine: stimulus pushes model results, a negedge monitor checks them.
module tb_mlp_seq_engine;
  localparam int N_IN = 4, N_HID = 4, N_OUT = 2, DW = 5, OW = 12;
  localparam int NW1 = N_IN*N_HID;
  localparam int NW  = NW1 + N_HID*N_OUT;
  localparam int WA  = $clog2(NW);
  localparam int YW  = N_OUT*OW;
  localparam int LAT = N_IN + N_HID;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_IN*DW-1:0] x_in;
  logic in_valid, in_ready, w_we, out_valid, out_ready;
  logic [WA-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [YW-1:0] y_out;

  always #5 clk = ~clk;

  mlp_seq_engine #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW), .OW(OW)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .y_out(y_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct { logic [YW-1:0] y; int acc; } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int mw[NW];
  logic [YW-1:0] exp_hold;
  bit seen, chk_idle;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: plain dot products, ReLU, then wrap or clamp to OW bits.
  function automatic logic [YW-1:0] model(input int xv[N_IN]);
    logic [YW-1:0] y;
    longint h, a, lim;
    y = '0;
    lim = longint'(1) <<< (OW-1);
    for (int o = 0; o < N_OUT; o++) begin
      a = 0;
      for (int j = 0; j < N_HID; j++) begin
        h = 0;
        for (int k = 0; k < N_IN; k++) h += longint'(xv[k]) * mw[k*N_HID + j];
        if (h < 0) h = 0;
        a += h * mw[NW1 + j*N_OUT + o];
      end
`ifdef MLP_SAT_EN
      if (a > lim - 1) a = lim - 1;
      if (a < -lim) a = -lim;
`endif
      y[o*OW +: OW] = a[OW-1:0];
    end
    return y;
  endfunction

  function automatic logic [YW-1:0] pk2(input int y0, input int y1);
    logic [YW-1:0] r;
    r[OW-1:0]    = y0[OW-1:0];
    r[2*OW-1:OW] = y1[OW-1:0];
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      seen = 0; chk_idle = 0; exp_hold = '0;
    end else begin
      if (chk_idle) begin
        chk("idle_after_ack", 64'(in_ready), 64'(1'b1));
        chk_idle = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          if (!seen) chk("unexpected_out_valid", 64'(out_valid), 64'(1'b0));
          seen = 1;
        end else begin
          if (!seen) chk("latency", 64'(cyc - q[0].acc), 64'(LAT));
          seen = 1;
          chk("y_out", 64'(y_out), 64'(q[0].y));
          chk("in_ready_in_out", 64'(in_ready), 64'(1'b0));
          if (out_ready) begin
            exp_hold = q[0].y;
            void'(q.pop_front());
            seen = 0;
            chk_idle = 1;
          end
        end
      end else begin
        seen = 0;
        chk("y_hold", 64'(y_out), 64'(exp_hold));
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  task automatic wait_idle();
    int t = 0;
    while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (!in_ready) chk("idle_timeout", 64'(in_ready), 64'(1'b1));
  endtask

  task automatic wr(input int addr, input int d, input bit upd);
    w_addr = WA'(addr); w_data = DW'(d); w_we = 1'b1;
    @(posedge clk); #1;
    w_we = 1'b0;
    if (upd && addr < NW) mw[addr] = d;
  endtask

  task automatic load_const(input int v1, input int v2);
    wait_idle();
    for (int a = 0; a < NW; a++) wr(a, (a < NW1) ? v1 : v2, 1'b1);
  endtask

  task automatic load_rand();
    wait_idle();
    for (int a = 0; a < NW; a++) wr(a, int'($urandom_range(0, 31)) - 16, 1'b1);
  endtask

  task automatic rand_x(output int xv[N_IN]);
    for (int k = 0; k < N_IN; k++) xv[k] = int'($urandom_range(0, 31)) - 16;
  endtask

  task automatic issue(input int xv[N_IN], input logic [YW-1:0] ye);
    exp_t e;
    wait_idle();
    if (!in_ready) return;
    for (int k = 0; k < N_IN; k++) x_in[k*DW +: DW] = DW'(xv[k]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.y = ye; e.acc = cyc;
    q.push_back(e);
  endtask

  initial begin
    int xv[N_IN];
    logic [YW-1:0] ye;
    int t;
    x_in = '0; in_valid = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;
    for (int a = 0; a < NW; a++) mw[a] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1'b1));
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_y_out", 64'(y_out), 64'(0));
    @(posedge clk); #1;

    load_const(1, 1);
    xv = '{1, 2, 3, 4};
    issue(xv, pk2(40, 40));

    load_const(-1, 1);
    issue(xv, pk2(0, 0));

    load_const(15, 15);
    xv = '{15, 15, 15, 15};
`ifdef MLP_SAT_EN
    issue(xv, pk2(2047, 2047));
`else
    issue(xv, pk2(752, 752));
`endif

    // Result held under backpressure while extra inputs are offered.
    load_rand();
    rand_x(xv);
    rdy_mode = 2;
    issue(xv, model(xv));
    t = 0;
    while (!out_valid && t < 30) begin @(posedge clk); #1; t++; end
    chk("stall_reach_out", 64'(out_valid), 64'(1'b1));
    for (int i = 0; i < 5; i++) begin
      x_in = N_IN*DW'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rdy_mode = 0;

    // A weight write while busy must be dropped.
    load_const(1, 1);
    wr(0, 3, 1'b1);
    for (int k = 0; k < N_IN; k++) xv[k] = int'($urandom_range(1, 15));
    ye = model(xv);
    issue(xv, ye);
    wr(0, 7, 1'b0);
    issue(xv, ye);

    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) load_rand();
      if (i % 5 == 2) begin
        wait_idle();
        wr(NW + int'($urandom_range(0, (1 << WA) - NW - 1)), int'($urandom_range(0, 31)) - 16, 1'b1);
      end
      rand_x(xv);
      issue(xv, model(xv));
    end

    // Reset in the middle of L2: no result, weights cleared.
    rdy_mode = 0;
    rand_x(xv);
    issue(xv, model(xv));
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    for (int a = 0; a < NW; a++) mw[a] = 0;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1'b1));
    repeat (12) @(posedge clk);
    #1;
    for (int k = 0; k < N_IN; k++) xv[k] = int'($urandom_range(1, 15));
    issue(xv, pk2(0, 0));
    rand_x(xv);
    issue(xv, model(xv));

    t = 0;
    while (q.size() > 0 && t < 200) begin @(posedge clk); #1; t++; end
    chk("drain_empty", 64'(q.size()), 64'(0));
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
